// File: rtl/score_pkg.sv
// Shared definitions for the Score-path partial-sum accumulator.
//   SCORE_* : default lane count and datapath widths
//   score_state_e : accumulator FSM state encoding
//   sat_add : unsigned add clamped to an arbitrary width (<= 32 bits)
package score_pkg;

   localparam int unsigned SCORE_LANES = 8;
   localparam int unsigned SCORE_IN_W  = 8;
   localparam int unsigned SCORE_ACC_W = 16;
   localparam int unsigned SCORE_OUT_W = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } score_state_e;

   // Returns {clipped, value}; value is clamped to 2^w-1 when a+b exceeds it.
   function automatic logic [32:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned w);
      logic [32:0] sum;
      logic [32:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (33'(1) << w) - 33'(1);
      if (sum > lim) begin
         sat_add = {1'b1, lim[31:0]};
      end else begin
         sat_add = {1'b0, sum[31:0]};
      end
   endfunction

endpackage

// File: rtl/score_fifo.sv
// Synchronous FIFO holding finished score vectors.
//   clk, rst : clock, synchronous active-high reset
//   push, wdata : write request and entry (ignored while full)
//   pop, rdata  : read request (ignored while empty) and head entry
//   full, empty, count : occupancy status, all derived from registers
module score_fifo #(
   parameter int unsigned WIDTH = 72,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array; contents are meaningless until written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/score_acc.sv
// Lane-parallel partial-sum accumulator for col_cim outputs.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid, in_last, psum : beat input; in_last closes a dot product
//   in_ready   : FIFO has room (depends on registered occupancy only)
//   out_valid, out_data, out_sat, out_ready : result FIFO head and handshake
//   busy       : a partial accumulation is held
module score_acc
   import score_pkg::*;
#(
   parameter int unsigned LANES = SCORE_LANES,
   parameter int unsigned IN_W  = SCORE_IN_W,
   parameter int unsigned ACC_W = SCORE_ACC_W,
   parameter int unsigned OUT_W = SCORE_OUT_W,
   parameter int unsigned SHIFT = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic                   in_last,
   input  logic [LANES*IN_W-1:0]  psum,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [LANES*OUT_W-1:0] out_data,
   output logic [LANES-1:0]       out_sat,
   input  logic                   out_ready,
   output logic                   busy
);

   localparam int unsigned DATA_W = LANES * OUT_W;
   localparam int unsigned ENT_W  = DATA_W + LANES;
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

   score_state_e state_q;
   score_state_e state_d;

   logic [LANES-1:0][ACC_W-1:0] acc_q;
   logic [LANES-1:0][ACC_W-1:0] acc_nxt;
   logic [LANES-1:0]            sat_q;
   logic [LANES-1:0]            clip;
   logic [LANES-1:0]            lane_sat;
   logic [LANES-1:0][OUT_W-1:0] lane_out;

   logic             accept;
   logic             push;
   logic             pop;
   logic             acc_load;
   logic             acc_clr;
   logic [ENT_W-1:0] push_entry;
   logic [ENT_W-1:0] head_entry;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full_unused;
   logic             fifo_empty;

   assign accept = in_valid && in_ready;

   // Per-lane saturating accumulate, scale and output clamp.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [32:0]      sum_w;
      logic             sum_unused;
      logic [ACC_W-1:0] scaled;
      logic             out_clip;

      assign sum_w       = sat_add(32'(acc_q[i]), 32'(psum[i*IN_W +: IN_W]), ACC_W);
      assign acc_nxt[i]  = sum_w[ACC_W-1:0];
      assign clip[i]     = sum_w[32];
      assign sum_unused  = ^sum_w[31:ACC_W];
      assign scaled      = acc_nxt[i] >> SHIFT;
      assign out_clip    = |(scaled >> OUT_W);
      assign lane_out[i] = out_clip ? '1 : scaled[OUT_W-1:0];
      // Result flag includes a clamp occurring on the closing beat itself.
      assign lane_sat[i] = out_clip | clip[i] | sat_q[i];
   end

   assign push_entry = {lane_sat, lane_out};

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      acc_load = 1'b0;
      acc_clr  = 1'b0;
      push     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (in_last) begin
                  push    = 1'b1;
                  acc_clr = 1'b1;
               end else begin
                  acc_load = 1'b1;
                  state_d  = ST_ACC;
               end
            end
         end
         ST_ACC: begin
            if (accept) begin
               if (in_last) begin
                  push    = 1'b1;
                  acc_clr = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  acc_load = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, accumulators and sticky clamp flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         sat_q   <= '0;
      end else begin
         state_q <= state_d;
         if (acc_clr) begin
            acc_q <= '0;
            sat_q <= '0;
         end else if (acc_load) begin
            acc_q <= acc_nxt;
            sat_q <= sat_q | clip;
         end
      end
   end

   score_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (push_entry),
      .pop   (pop),
      .rdata (head_entry),
      .full  (fifo_full_unused),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign in_ready  = (fifo_count != CNT_W'(DEPTH));
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign out_data  = head_entry[DATA_W-1:0];
   assign out_sat   = head_entry[ENT_W-1 -: LANES];
   assign busy      = (state_q == ST_ACC);

endmodule

// File: tb/tb_score_acc.sv
module tb_score_acc;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_last;
   logic [63:0] psum;
   logic        in_ready;
   logic        out_valid;
   logic [63:0] out_data;
   logic [7:0]  out_sat;
   logic        out_ready;
   logic        busy;

   int total;
   int bad;
   int busy_hi;

   // Reference model: unbounded integer lane sums, clamped per the rules.
   int          m_acc [8];
   bit          m_sat [8];
   bit          m_burst;
   logic [71:0] m_q [$];

   score_acc dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .psum      (psum),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_acc[i] = 0;
         m_sat[i] = 1'b0;
      end
      m_burst = 1'b0;
      m_q.delete();
   endtask

   task automatic model_beat(input bit last, input logic [63:0] p);
      logic [71:0] e;
      int          s;
      int          r;
      e = '0;
      for (int i = 0; i < 8; i++) begin
         s = m_acc[i] + int'(p[i*8 +: 8]);
         if (s > 65535) begin
            s = 65535;
            m_sat[i] = 1'b1;
         end
         m_acc[i] = s;
         if (last) begin
            r = m_acc[i] / 16;
            if (r > 255) begin
               e[i*8 +: 8] = 8'hFF;
               e[64 + i]   = 1'b1;
            end else begin
               e[i*8 +: 8] = 8'(r);
               e[64 + i]   = m_sat[i];
            end
         end
      end
      if (last) begin
         m_q.push_back(e);
         for (int i = 0; i < 8; i++) begin
            m_acc[i] = 0;
            m_sat[i] = 1'b0;
         end
         m_burst = 1'b0;
      end else begin
         m_burst = 1'b1;
      end
   endtask

   // One clock cycle: drive, check outputs against the model, advance.
   task automatic step(input bit v, input bit l, input logic [63:0] p, input bit ordy);
      bit acc_ok;
      bit pop_ok;
      in_valid  = v;
      in_last   = l;
      psum      = p;
      out_ready = ordy;
      #1;
      chk("in_ready", 72'(in_ready), 72'(m_q.size() != 4));
      chk("out_valid", 72'(out_valid), 72'(m_q.size() != 0));
      chk("busy", 72'(busy), 72'(m_burst));
      if (busy) busy_hi++;
      if (m_q.size() != 0) begin
         chk("out_data", 72'(out_data), 72'(m_q[0][63:0]));
         chk("out_sat", 72'(out_sat), 72'(m_q[0][71:64]));
      end
      acc_ok = v && (m_q.size() != 4);
      pop_ok = ordy && (m_q.size() != 0);
      if (pop_ok) void'(m_q.pop_front());
      if (acc_ok) model_beat(l, p);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [63:0] p;
      total     = 0;
      bad       = 0;
      busy_hi   = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      psum      = '0;
      out_ready = 1'b0;
      model_reset();
      @(posedge clk);
      do_reset();

      // Reset state.
      chk("rst_in_ready", 72'(in_ready), 72'(1));
      chk("rst_out_valid", 72'(out_valid), 72'(0));
      chk("rst_busy", 72'(busy), 72'(0));
      step(1'b0, 1'b0, '0, 1'b1);

      // Single-beat dot product.
      p = 64'hF000_0000_0000_0020;
      step(1'b1, 1'b1, p, 1'b0);
      chk("single_valid", 72'(out_valid), 72'(1));
      chk("single_lane0", 72'(out_data[7:0]), 72'(8'h02));
      chk("single_lane7", 72'(out_data[63:56]), 72'(8'h0F));
      chk("single_sat", 72'(out_sat), 72'(0));
      step(1'b0, 1'b0, '0, 1'b1);

      // Four-beat burst of 0xFF.
      busy_hi = 0;
      for (int b = 0; b < 4; b++) step(1'b1, (b == 3), {8{8'hFF}}, 1'b1);
      chk("burst4_data", 72'(out_data), 72'({8{8'h3F}}));
      chk("burst4_sat", 72'(out_sat), 72'(0));
      step(1'b0, 1'b0, '0, 1'b1);
      chk("burst4_busy_cycles", 72'(busy_hi), 72'(3));

      // Output clamp after 17 beats.
      for (int b = 0; b < 17; b++) step(1'b1, (b == 16), {8{8'hFF}}, 1'b0);
      chk("clamp17_data", 72'(out_data), 72'({8{8'hFF}}));
      chk("clamp17_sat", 72'(out_sat), 72'(8'hFF));
      step(1'b0, 1'b0, '0, 1'b1);

      // Accumulator clamp after 258 beats.
      for (int b = 0; b < 258; b++) step(1'b1, (b == 257), {8{8'hFF}}, 1'b0);
      chk("clamp258_data", 72'(out_data), 72'({8{8'hFF}}));
      chk("clamp258_sat", 72'(out_sat), 72'(8'hFF));
      step(1'b0, 1'b0, '0, 1'b1);

      // Backpressure: fill with results 1..4 on lane0.
      for (int b = 1; b <= 4; b++) step(1'b1, 1'b1, 64'(b * 16), 1'b0);
      chk("full_in_ready", 72'(in_ready), 72'(0));
      step(1'b1, 1'b1, 64'h50, 1'b0);
      for (int b = 1; b <= 4; b++) begin
         chk("bp_order", 72'(out_data[7:0]), 72'(b));
         step(1'b0, 1'b0, '0, 1'b1);
      end
      chk("bp_drained", 72'(out_valid), 72'(0));

      // Concurrent push/pop at count=2, pointer wrap over 10 pushes.
      step(1'b1, 1'b1, 64'h10, 1'b0);
      step(1'b1, 1'b1, 64'h20, 1'b0);
      for (int b = 0; b < 10; b++) step(1'b1, 1'b1, {$urandom, $urandom}, 1'b1);
      chk("concurrent_depth", 72'(m_q.size()), 72'(2));
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1);
      chk("concurrent_drained", 72'(out_valid), 72'(0));

      // Reset mid-burst with an entry already queued.
      step(1'b1, 1'b1, 64'h70, 1'b0);
      step(1'b1, 1'b0, 64'h10, 1'b0);
      step(1'b1, 1'b0, 64'h10, 1'b0);
      do_reset();
      chk("rstmid_out_valid", 72'(out_valid), 72'(0));
      chk("rstmid_busy", 72'(busy), 72'(0));
      step(1'b1, 1'b1, 64'h10, 1'b0);
      chk("rstmid_lane0", 72'(out_data[7:0]), 72'(8'h01));
      step(1'b0, 1'b0, '0, 1'b1);
      chk("rstmid_single_entry", 72'(out_valid), 72'(0));

      // Randomized traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
              {$urandom, $urandom}, ($urandom_range(0, 2) != 0));
      end
      for (int n = 0; n < 8; n++) step(1'b0, 1'b0, '0, 1'b1);
      chk("final_empty", 72'(out_valid), 72'(m_q.size() != 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
